// File: rtl/vector_xing_stager.sv
// Builds a wide vector from 32-bit word writes and stages committed snapshots
// for the clock-domain crossing. Commits made while busy are coalesced.
module vector_xing_stager #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter bit          AUTO_COMMIT = 1'b0,
    localparam int unsigned NUM_WORDS  = DATA_WIDTH / 32,
    localparam int unsigned AW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  iclk,
    input  logic                  ireset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strb,
    input  logic                  commit,
    input  logic                  xready,
    output logic                  xpush,
    output logic [DATA_WIDTH-1:0] xdata,
    output logic                  pending,
    output logic [15:0]           push_count,
    output logic [15:0]           coalesce_count,
    input  logic                  clear_stats
);

    logic [31:0] shadow_q    [NUM_WORDS];
    logic [31:0] shadow_next [NUM_WORDS];
    logic [31:0] staged_q    [NUM_WORDS];
    logic        commit_eff;
    logic        coalesce;

    // Merge the current-cycle write; unmatched (out-of-range) addresses hit no word.
    always_comb begin
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
            shadow_next[w] = shadow_q[w];
            if (wr_en && (wr_addr == AW'(w))) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (wr_strb[b]) begin
                        shadow_next[w][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign commit_eff = commit | (AUTO_COMMIT & wr_en & (wr_addr == AW'(NUM_WORDS - 1)));
    assign xpush      = pending & xready & ~ireset;
    assign coalesce   = commit_eff & pending & ~xpush;

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_xdata
        assign xdata[32*g +: 32] = staged_q[g];
    end

    // Shadow, staged snapshot, pending flag and statistics.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                shadow_q[w] <= 32'd0;
                staged_q[w] <= 32'd0;
            end
            pending        <= 1'b0;
            push_count     <= 16'd0;
            coalesce_count <= 16'd0;
        end else begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                shadow_q[w] <= shadow_next[w];
                if (commit_eff) begin
                    staged_q[w] <= shadow_next[w];
                end
            end

            if (commit_eff) begin
                pending <= 1'b1;
            end else if (xpush) begin
                pending <= 1'b0;
            end

            if (clear_stats) begin
                push_count     <= 16'd0;
                coalesce_count <= 16'd0;
            end else begin
                if (xpush) begin
                    push_count <= push_count + 16'd1;
                end
                if (coalesce && (coalesce_count != 16'hFFFF)) begin
                    coalesce_count <= coalesce_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_xing_stager.sv
// Directed, table-driven bench for vector_xing_stager (128-bit, auto-commit and 96-bit builds).
module tb_vector_xing_stager;

    logic         iclk = 1'b0;
    logic         ireset = 1'b1;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_addr = 2'd0;
    logic [31:0]  wr_data = 32'd0;
    logic [3:0]   wr_strb = 4'd0;
    logic         commit = 1'b0;
    logic         xready = 1'b0;
    logic         clear_stats = 1'b0;

    logic         xpush, pending;
    logic [127:0] xdata;
    logic [15:0]  push_count, coalesce_count;
    logic         xpush_ac, pending_ac;
    logic [127:0] xdata_ac;
    logic [15:0]  push_count_ac, coalesce_count_ac;
    logic         xpush_96, pending_96;
    logic [95:0]  xdata_96;
    logic [15:0]  push_count_96, coalesce_count_96;

    int tests  = 0;
    int failed = 0;

    always #5 iclk = ~iclk;

    vector_xing_stager #(.DATA_WIDTH(128), .AUTO_COMMIT(1'b0)) dut (
        .iclk(iclk), .ireset(ireset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .commit(commit), .xready(xready), .xpush(xpush), .xdata(xdata),
        .pending(pending), .push_count(push_count), .coalesce_count(coalesce_count),
        .clear_stats(clear_stats)
    );

    vector_xing_stager #(.DATA_WIDTH(128), .AUTO_COMMIT(1'b1)) dut_ac (
        .iclk(iclk), .ireset(ireset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .commit(commit), .xready(xready), .xpush(xpush_ac), .xdata(xdata_ac),
        .pending(pending_ac), .push_count(push_count_ac), .coalesce_count(coalesce_count_ac),
        .clear_stats(clear_stats)
    );

    vector_xing_stager #(.DATA_WIDTH(96), .AUTO_COMMIT(1'b0)) dut_96 (
        .iclk(iclk), .ireset(ireset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .commit(commit), .xready(xready), .xpush(xpush_96), .xdata(xdata_96),
        .pending(pending_96), .push_count(push_count_96), .coalesce_count(coalesce_count_96),
        .clear_stats(clear_stats)
    );

    typedef struct {
        logic         we;
        logic [1:0]   addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        logic         cm;
        logic         xr;
        logic         clr;
        logic         e_xp;
        logic         e_pend;
        logic [127:0] e_xd;
        logic [15:0]  e_pc;
        logic [15:0]  e_cc;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    localparam logic [127:0] V1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] V2 = 128'h44444444_33333333_22BB22DD_11111111;
    localparam logic [127:0] V3 = 128'h44444444_33333333_22BB22DD_A0A0A0A0;
    localparam logic [127:0] V4 = 128'h44444444_C2C2C2C2_22BB22DD_A0A0A0A0;
    localparam logic [127:0] V5 = 128'h55555555_C2C2C2C2_22BB22DD_A0A0A0A0;
    localparam logic [127:0] V6 = 128'h66666666_C2C2C2C2_22BB22DD_A0A0A0A0;

    function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic cm, input logic xr,
                                input logic clr, input logic e_xp, input logic e_pend,
                                input logic [127:0] e_xd, input logic [15:0] e_pc,
                                input logic [15:0] e_cc);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.strb = strb; v.cm = cm; v.xr = xr;
        v.clr = clr; v.e_xp = e_xp; v.e_pend = e_pend; v.e_xd = e_xd; v.e_pc = e_pc;
        v.e_cc = e_cc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic cm, input logic xr, input logic clr);
        wr_en = we; wr_addr = addr; wr_data = data; wr_strb = strb;
        commit = cm; xready = xr; clear_stats = clr;
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    logic [127:0] prev_xd;

    initial begin
        // Table: inputs for one cycle; xpush checked before the edge, state after it.
        tbl[0]  = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 0, 0, 128'h0, 16'd0, 16'd0);
        tbl[1]  = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 0, 0, 128'h0, 16'd0, 16'd0);
        tbl[2]  = mk(1, 0, 32'h11111111, 4'hF, 0, 1, 0, 0, 0, 128'h0, 16'd0, 16'd0);
        tbl[3]  = mk(1, 1, 32'h22222222, 4'hF, 0, 1, 0, 0, 0, 128'h0, 16'd0, 16'd0);
        tbl[4]  = mk(1, 2, 32'h33333333, 4'hF, 0, 1, 0, 0, 0, 128'h0, 16'd0, 16'd0);
        tbl[5]  = mk(1, 3, 32'h44444444, 4'hF, 0, 1, 0, 0, 0, 128'h0, 16'd0, 16'd0);
        tbl[6]  = mk(0, 0, 32'h0,        4'h0, 1, 1, 0, 0, 1, V1,     16'd0, 16'd0);
        tbl[7]  = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 1, 0, V1,     16'd1, 16'd0);
        tbl[8]  = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 0, 0, V1,     16'd1, 16'd0);
        tbl[9]  = mk(1, 1, 32'hAABBCCDD, 4'h5, 1, 0, 0, 0, 1, V2,     16'd1, 16'd0);
        tbl[10] = mk(1, 0, 32'hA0A0A0A0, 4'hF, 1, 0, 0, 0, 1, V3,     16'd1, 16'd1);
        tbl[11] = mk(1, 2, 32'hC2C2C2C2, 4'hF, 1, 0, 0, 0, 1, V4,     16'd1, 16'd2);
        tbl[12] = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 1, 0, V4,     16'd2, 16'd2);
        tbl[13] = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 0, 0, V4,     16'd2, 16'd2);
        tbl[14] = mk(1, 3, 32'h55555555, 4'hF, 1, 0, 0, 0, 1, V5,     16'd2, 16'd2);
        tbl[15] = mk(1, 3, 32'h66666666, 4'hF, 1, 1, 0, 1, 1, V6,     16'd3, 16'd2);
        tbl[16] = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 1, 0, V6,     16'd4, 16'd2);
        tbl[17] = mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 0, 0, V6,     16'd0, 16'd0);
        tbl[18] = mk(0, 0, 32'h0,        4'h0, 1, 0, 0, 0, 1, V6,     16'd0, 16'd0);
        tbl[19] = mk(0, 0, 32'h0,        4'h0, 0, 1, 1, 1, 0, V6,     16'd0, 16'd0);

        // Reset with xready high.
        ireset = 1'b1;
        xready = 1'b1;
        tick();
        tick();
        chk("reset xpush", 128'(xpush), 128'd0);
        ireset = 1'b0;
        chk("reset pending", 128'(pending), 128'd0);
        chk("reset xdata", xdata, 128'd0);
        chk("reset push_count", 128'(push_count), 128'd0);
        chk("reset coalesce_count", 128'(coalesce_count), 128'd0);

        prev_xd = 128'd0;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].cm, tbl[i].xr,
                  tbl[i].clr);
            #1;
            chk($sformatf("v%0d xpush", i), 128'(xpush), 128'(tbl[i].e_xp));
            if (tbl[i].e_xp) begin
                chk($sformatf("v%0d xdata@push", i), xdata, prev_xd);
            end
            tick();
            chk($sformatf("v%0d pending", i), 128'(pending), 128'(tbl[i].e_pend));
            chk($sformatf("v%0d xdata", i), xdata, tbl[i].e_xd);
            chk($sformatf("v%0d push_count", i), 128'(push_count), 128'(tbl[i].e_pc));
            chk($sformatf("v%0d coalesce_count", i), 128'(coalesce_count), 128'(tbl[i].e_cc));
            prev_xd = tbl[i].e_xd;
        end

        // Auto-commit: a write to the last word commits on its own.
        drive(0, 0, 32'h0, 4'h0, 0, 0, 0);
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        drive(1, 3, 32'h77777777, 4'hF, 0, 0, 0);
        tick();
        chk("ac pending", 128'(pending_ac), 128'd1);
        chk("ac xdata", xdata_ac, 128'h77777777_00000000_00000000_00000000);
        chk("no-ac pending", 128'(pending), 128'd0);
        drive(0, 0, 32'h0, 4'h0, 0, 1, 0);
        #1;
        chk("ac xpush", 128'(xpush_ac), 128'd1);
        tick();
        chk("ac push_count", 128'(push_count_ac), 128'd1);
        chk("ac pending after push", 128'(pending_ac), 128'd0);

        // Zero-strobe write to the last word still commits, without changing data.
        drive(1, 3, 32'h88888888, 4'h0, 0, 0, 0);
        tick();
        chk("ac strb0 pending", 128'(pending_ac), 128'd1);
        chk("ac strb0 xdata", xdata_ac, 128'h77777777_00000000_00000000_00000000);

        // Reset while pending: xpush masked during reset, state discarded after.
        drive(0, 0, 32'h0, 4'h0, 0, 1, 0);
        ireset = 1'b1;
        #1;
        chk("ac xpush in reset", 128'(xpush_ac), 128'd0);
        tick();
        ireset = 1'b0;
        chk("ac pending after reset", 128'(pending_ac), 128'd0);
        chk("ac xdata after reset", xdata_ac, 128'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("ac idle xpush %0d", k), 128'(xpush_ac), 128'd0);
            tick();
        end

        // 96-bit build: address 3 is out of range and must be ignored.
        drive(1, 3, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        tick();
        drive(1, 2, 32'h12345678, 4'hF, 1, 0, 0);
        tick();
        drive(0, 0, 32'h0, 4'h0, 0, 0, 0);
        chk("w96 pending", 128'(pending_96), 128'd1);
        chk("w96 xdata", 128'(xdata_96), 128'(96'h12345678_00000000_00000000));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vector_xing_stager.md
Name: vector_xing_stager

Overview:
- Upstream feeder for the clock-domain vector crossing: builds a wide configuration vector from 32-bit word writes on iclk, then hands committed snapshots to the crossing through its ready/push handshake.
- Coalesces commits made while the crossing is busy: only the newest committed vector is sent.
- Keeps statistics for software: pushes completed and commits superseded.

Parameters:
- DATA_WIDTH, 128, width of the assembled vector; must be a multiple of 32 and at least 32.
- AUTO_COMMIT, 0, when 1, any write to word NUM_WORDS-1 also acts as a commit.
- NUM_WORDS (localparam), DATA_WIDTH/32.
- AW (localparam), max(1, $clog2(NUM_WORDS)).

Ports:
- iclk  in  1  clock; all signals synchronous to it.
- ireset  in  1  reset.
- wr_en  in  1  qualifies a word write.
- wr_addr  in  AW  word index; word k occupies shadow bits [32k+31:32k].
- wr_data  in  32  write data.
- wr_strb  in  4  byte enables; bit b selects wr_data[8b+7:8b].
- commit  in  1  single-cycle request to snapshot the shadow for transfer.
- xready  in  1  crossing is ready for new data.
- xpush  out  1  push strobe to the crossing.
- xdata  out  DATA_WIDTH  staged vector to the crossing.
- pending  out  1  a staged vector has not yet been pushed.
- push_count  out  16  completed pushes; wraps.
- coalesce_count  out  16  superseded commits; saturates at 16'hFFFF.
- clear_stats  in  1  zeroes both counters.

Behaviour:
- Reset is ireset, synchronous, active-high; clock iclk.
- Reset values: shadow, xdata, pending, push_count and coalesce_count are all 0. xpush is 0 whenever ireset is high.

Write path:
- When wr_en is high and wr_addr < NUM_WORDS, each strobed byte of shadow word wr_addr takes its wr_data byte at the next edge.
- An out-of-range wr_addr is ignored (no state change).
- wr_strb = 0 performs no byte update, but still counts as a write for AUTO_COMMIT.
- shadow_next is the shadow value with the current-cycle write merged in.

Commit:
- commit_eff = commit | (AUTO_COMMIT & wr_en & wr_addr == NUM_WORDS-1).
- On commit_eff, xdata <= shadow_next, so a write and a commit in the same cycle include that write.
- xdata changes only on commit_eff.

Push:
- xpush = pending & xready & ~ireset (combinational).
- The crossing captures xdata in the xpush cycle, so xdata is stable in that cycle.
- Latency: a commit at edge N gives pending=1 after N. If xready is high, xpush is high in the cycle after N, i.e. one cycle after the commit cycle.

pending update, per edge:
- commit_eff=1: pending <= 1.
- Else if xpush=1: pending <= 0.
- Else: pending holds.
- Commit and push in the same cycle: the crossing takes the old xdata, the new xdata is staged, and pending stays 1, giving a second push later.

Coalescing:
- A commit_eff while pending=1 and xpush=0 increments coalesce_count (saturating).
- A commit in the same cycle as a push is not a coalesce.

Counters:
- push_count increments on every xpush cycle.
- clear_stats has priority over increments in the same cycle; both counters become 0.

Reset mid-transfer:
- Staged data and pending are discarded. No xpush occurs until a new commit.

Implementation notes:
- No FSM beyond the pending flag.
- Shadow and staged registers are flop arrays of NUM_WORDS x 32.

Test Plan:
- Reset then idle, xready=1: xpush never asserts, xdata=0, and both counters read 0.
- DATA_WIDTH=128: write words 0..3 with 32'h11111111..32'h44444444 (strb=F), commit with xready=1 -> one xpush one cycle after commit, xdata=128'h44444444_33333333_22222222_11111111, push_count=1.
- Partial strobe: write word 1 with 32'hAABBCCDD, strb=4'b0101, then commit -> word 1 = 32'h22BB22DD, other words unchanged.
- Hold xready=0 and issue 3 commits of distinct data, then raise xready -> exactly one xpush carrying the third vector, coalesce_count=2.
- Commit coincident with an xpush cycle -> the crossing receives the old value, the new value is pushed on the next ready cycle, push_count +2, and coalesce_count unchanged.
- AUTO_COMMIT=1: write word 3 only -> pending set, xpush follows. Then assert ireset while pending=1 and xready=0 -> pending=0, xdata=0, and no xpush after reset.
